// File: rtl/baser_257b_transcoder_if.sv
// Block-stream bundle between the 64b/66b generator, the 256b/257b transcoder
// and the 257b checker: 66b block input side plus transcoded-word output side.
interface baser_257b_transcoder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TC_WIDTH   = 257
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic [1:0]            i_sh;
    logic                  o_valid;
    logic                  i_ready;
    logic [TC_WIDTH-1:0]   o_tx_coded;

    // Transcoder side.
    modport slave (
        input  i_valid,
        input  i_data,
        input  i_sh,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_tx_coded
    );

    // Block source / word sink side.
    modport master (
        output i_valid,
        output i_data,
        output i_sh,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_tx_coded
    );
endinterface

// File: rtl/baser_257b_transcoder.sv
// TX 256b/257b transcoder: gathers four 66b blocks, replaces malformed blocks
// with error control blocks, and emits one registered 257b word per group.
module baser_257b_transcoder #(
    parameter int         DATA_WIDTH = 64,
    parameter int         TC_WIDTH   = 257,
    parameter logic [6:0] ERR_CHAR   = 7'h1E
) (
    input  logic                          clk,
    input  logic                          i_rst,
    baser_257b_transcoder_if.slave        bus,
    output logic [31:0]                   o_tc_count,
    output logic [31:0]                   o_err_count
);
    localparam logic [7:0] ERR_TYPE = 8'h1E;

    logic [1:0]            slot_q;
    logic [DATA_WIDTH-1:0] buf_data_q [3];
    logic [2:0]            buf_flag_q;

    logic                  accept;
    logic                  load;
    logic                  norm_is_data;
    logic                  norm_err;
    logic [DATA_WIDTH-1:0] norm_data;

    logic [3:0]            flags;
    logic [DATA_WIDTH-1:0] blk [4];
    int                    first_ctrl;
    logic [TC_WIDTH-1:0]   tc_word;

    logic                  valid_q;
    logic [TC_WIDTH-1:0]   tx_q;

    function automatic logic is_known_type(input logic [7:0] block_type);
        case (block_type)
            8'h1E, 8'h78, 8'h4B, 8'h87, 8'h99, 8'hAA,
            8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // Normalize the incoming block: anything that is neither data nor a
    // recognised control type becomes an error control block.
    always_comb begin
        norm_is_data = (bus.i_sh == 2'b01);
        norm_err     = !norm_is_data &&
                       !((bus.i_sh == 2'b10) && is_known_type(bus.i_data[7:0]));
        norm_data    = norm_err ? {{8{ERR_CHAR}}, ERR_TYPE} : bus.i_data;
    end

    // Only the 4th slot can stall, and only while an unconsumed word is held.
    assign bus.o_ready = !((slot_q == 2'd3) && valid_q && !bus.i_ready);
    assign accept      = bus.i_valid && bus.o_ready;
    assign load        = accept && (slot_q == 2'd3);

    // NOTE: the group buffer has no reset; clearing slot_q makes stale entries
    // unreachable because every slot is rewritten before it is read again.
    always_ff @(posedge clk) begin
        if (accept && (slot_q != 2'd3)) begin
            buf_data_q[slot_q] <= norm_data;
            buf_flag_q[slot_q] <= norm_is_data;
        end
    end

    // Build the 257b word from the three buffered blocks and the current one.
    always_comb begin
        flags  = {norm_is_data, buf_flag_q};
        blk[0] = buf_data_q[0];
        blk[1] = buf_data_q[1];
        blk[2] = buf_data_q[2];
        blk[3] = norm_data;

        first_ctrl = 3;
        for (int i = 3; i >= 0; i--) begin
            if (!flags[i]) first_ctrl = i;
        end

        tc_word = '0;
        if (&flags) begin
            tc_word[0] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tc_word[1 + DATA_WIDTH*i +: DATA_WIDTH] = blk[i];
            end
        end else begin
            tc_word[4:1] = flags;
            for (int i = 0; i < 4; i++) begin
                if (i < first_ctrl) begin
                    tc_word[5 + DATA_WIDTH*i +: DATA_WIDTH] = blk[i];
                end else if (i == first_ctrl) begin
                    // First control block keeps only the high type nibble.
                    tc_word[5 + DATA_WIDTH*i +: 4]            = blk[i][7:4];
                    tc_word[9 + DATA_WIDTH*i +: DATA_WIDTH-8] = blk[i][DATA_WIDTH-1:8];
                end else begin
                    tc_word[1 + DATA_WIDTH*i +: DATA_WIDTH] = blk[i];
                end
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            slot_q      <= 2'd0;
            valid_q     <= 1'b0;
            tx_q        <= '0;
            o_tc_count  <= 32'd0;
            o_err_count <= 32'd0;
        end else begin
            if (accept) begin
                slot_q <= slot_q + 2'd1;
            end
            if (load) begin
                tx_q       <= tc_word;
                valid_q    <= 1'b1;
                o_tc_count <= o_tc_count + 32'd1;
            end else if (bus.i_ready) begin
                valid_q <= 1'b0;
            end
            if (accept && norm_err) begin
                o_err_count <= o_err_count + 32'd1;
            end
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_tx_coded = tx_q;
endmodule

// File: tb/tb_baser_257b_transcoder.sv
// Directed bench for baser_257b_transcoder: hand-built expected 257b words for
// all-data, mixed, start, error, backpressure and mid-group reset cases.
module tb_baser_257b_transcoder;
    localparam logic [63:0] AA   = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [55:0] E56  = {8{7'h1E}};
    localparam logic [63:0] EBLK = {E56, 8'h1E};

    logic        clk;
    logic        i_rst;
    logic [31:0] o_tc_count;
    logic [31:0] o_err_count;
    int          total;
    int          bad;

    baser_257b_transcoder_if bus ();

    baser_257b_transcoder dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .bus         (bus),
        .o_tc_count  (o_tc_count),
        .o_err_count (o_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [256:0] got, input logic [256:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Offer one block starting at a negedge; returns at the negedge after it is taken.
    task automatic send(input logic [63:0] d, input logic [1:0] sh);
        int n;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_sh    = sh;
        #1;
        n = 0;
        while (!bus.o_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.o_ready) check("send_timeout", bus.o_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        bus.i_valid = 1'b0;
        for (int i = 0; i < cycles; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [256:0] w1, w2;
        total       = 0;
        bad         = 0;
        i_rst       = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_sh    = 2'b01;
        bus.i_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_tx", bus.o_tx_coded, '0);
        check("rst_tc", o_tc_count, 32'd0);
        check("rst_err", o_err_count, 32'd0);
        check("rst_ready", bus.o_ready, 1'b1);
        i_rst = 1'b0;
        @(negedge clk);

        // All data, with one-cycle latency and drain
        send(AA, 2'b01); send(AA, 2'b01); send(AA, 2'b01);
        check("alldata_early", bus.o_valid, 1'b0);
        send(AA, 2'b01);
        check("alldata_valid", bus.o_valid, 1'b1);
        check("alldata_word", bus.o_tx_coded, {AA, AA, AA, AA, 1'b1});
        check("alldata_tc", o_tc_count, 32'd1);
        idle(1);
        check("alldata_drain", bus.o_valid, 1'b0);

        // Mixed: valid control 0x1E in slot 2
        send(64'h0123_4567_89AB_CDEF, 2'b01);
        send(64'hFEDC_BA98_7654_3210, 2'b01);
        send(EBLK, 2'b10);
        send(64'h5555_5555_5555_5555, 2'b01);
        check("mixed_word", bus.o_tx_coded,
              {64'h5555_5555_5555_5555, E56, 4'h1,
               64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 4'b1011, 1'b0});
        check("mixed_err", o_err_count, 32'd0);
        check("mixed_tc", o_tc_count, 32'd2);

        // Start block in slot 0, idle gap inside the group
        send({AA[55:0], 8'h78}, 2'b10);
        idle(3);
        check("start_gap", bus.o_valid, 1'b0);
        send(64'h1111_2222_3333_4444, 2'b01);
        send(64'h5555_6666_7777_8888, 2'b01);
        send(64'h9999_AAAA_BBBB_CCCC, 2'b01);
        check("start_word", bus.o_tx_coded,
              {64'h9999_AAAA_BBBB_CCCC, 64'h5555_6666_7777_8888,
               64'h1111_2222_3333_4444, AA[55:0], 4'h7, 4'b1110, 1'b0});
        check("start_tc", o_tc_count, 32'd3);

        // Error replacement: bad sync header, then unknown type 0x55
        send(64'hDEAD_BEEF_DEAD_BEEF, 2'b11);
        send({56'h12_3456_789A_BCDE, 8'h55}, 2'b10);
        send(64'h0F0F_0F0F_0F0F_0F0F, 2'b01);
        send(64'hF0F0_F0F0_F0F0_F0F0, 2'b01);
        check("err_word", bus.o_tx_coded,
              {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
               EBLK, E56, 4'h1, 4'b1100, 1'b0});
        check("err_count", o_err_count, 32'd2);
        check("err_tc", o_tc_count, 32'd4);
        idle(1);

        // Backpressure: 8 blocks, i_ready low
        w1 = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
              64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0, 1'b1};
        w2 = {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
              64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0, 1'b1};
        bus.i_ready = 1'b0;
        send(64'hA0A0_A0A0_A0A0_A0A0, 2'b01);
        send(64'hA1A1_A1A1_A1A1_A1A1, 2'b01);
        send(64'hA2A2_A2A2_A2A2_A2A2, 2'b01);
        send(64'hA3A3_A3A3_A3A3_A3A3, 2'b01);
        check("bp_word1", bus.o_tx_coded, w1);
        send(64'hB0B0_B0B0_B0B0_B0B0, 2'b01);
        send(64'hB1B1_B1B1_B1B1_B1B1, 2'b01);
        send(64'hB2B2_B2B2_B2B2_B2B2, 2'b01);
        check("bp_hold_a", bus.o_tx_coded, w1);
        bus.i_valid = 1'b1;
        bus.i_data  = 64'hB3B3_B3B3_B3B3_B3B3;
        bus.i_sh    = 2'b01;
        #1;
        check("bp_stall_ready", bus.o_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("bp_hold_b", bus.o_tx_coded, w1);
        check("bp_hold_valid", bus.o_valid, 1'b1);
        check("bp_hold_tc", o_tc_count, 32'd5);
        bus.i_ready = 1'b1;
        #1;
        check("bp_release_ready", bus.o_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("bp_word2", bus.o_tx_coded, w2);
        check("bp_valid2", bus.o_valid, 1'b1);
        check("bp_tc", o_tc_count, 32'd6);
        idle(1);
        check("bp_drain", bus.o_valid, 1'b0);

        // Reset mid-group
        send(64'h7777_7777_7777_7777, 2'b01);
        send(64'h8888_8888_8888_8888, 2'b01);
        bus.i_valid = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check("mrst_valid", bus.o_valid, 1'b0);
        check("mrst_tx", bus.o_tx_coded, '0);
        check("mrst_tc", o_tc_count, 32'd0);
        check("mrst_err", o_err_count, 32'd0);
        check("mrst_ready", bus.o_ready, 1'b1);
        @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        send(64'hC0C0_C0C0_C0C0_C0C0, 2'b01);
        send(64'hC1C1_C1C1_C1C1_C1C1, 2'b01);
        send(64'hC2C2_C2C2_C2C2_C2C2, 2'b01);
        check("mrst_early", bus.o_valid, 1'b0);
        send(64'hC3C3_C3C3_C3C3_C3C3, 2'b01);
        check("mrst_word", bus.o_tx_coded,
              {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
               64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0, 1'b1});
        check("mrst_tc", o_tc_count, 32'd1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/baser_257b_transcoder.md
# baser_257b_transcoder

TX-side 256b/257b transcoder. It collects four 64b/66b blocks and emits one 257b transcoded block whose layout is what the 257b checker on the RX path consumes. It also replaces malformed 66b blocks with error control blocks and counts transcoded and errored blocks. It sits between the 64b/66b block generator and the 257b checker in the BASE-R verification chain.

## Interface
- DATA_WIDTH, 64, payload width of one 66b block
- TC_WIDTH, 257, transcoded block width
- ERR_CHAR, 7'h1E, 7-bit control character used to fill error replacement blocks
- clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input 66b block valid
- o_ready  out  1  transcoder can accept a block this cycle (combinational)
- i_data  in  DATA_WIDTH  66b payload; for control blocks, [7:0] is the block type
- i_sh  in  2  sync header: 2'b01 = data, 2'b10 = control
- o_valid  out  1  o_tx_coded holds a valid 257b block
- i_ready  in  1  downstream accepts o_tx_coded
- o_tx_coded  out  TC_WIDTH  transcoded block
- o_tc_count  out  32  number of 257b blocks produced
- o_err_count  out  32  number of 66b blocks replaced by error blocks

## Operation
- **Accept.** A block is accepted when i_valid && o_ready. A 2-bit slot counter (0..3) selects the buffer entry. It increments on each accept and wraps 3 -> 0 on the 4th accept.
- **Normalize at accept.** The block is valid in either of these cases:
  - i_sh == 2'b01 (data);
  - i_sh == 2'b10 and i_data[7:0] is one of {1E, 78, 4B, 87, 99, AA, B4, CC, D2, E1, FF}.
  - Any other block is stored as a control block with type 8'h1E and payload {8{ERR_CHAR}}, and o_err_count increments.
- **Transcode on the 4th accept.** The 257b word is built from the three buffered entries plus the current normalized block.
  - Flag f[i] = 1 if block i is data, for i = 0..3.
  - **All data:** out[0] = 1 and out[1+64i +:64] = data_i.
  - **Otherwise:** out[0] = 0 and out[4:1] = f. Let k be the lowest index with f[k] = 0.
    - i < k: out[5+64i +:64] = data_i.
    - i = k: out[5+64k +:4] = type_k[7:4] and out[9+64k +:56] = data_k[63:8].
    - i > k: out[1+64i +:64] = full 64b of block i (control blocks keep their full type byte).
- **Output register.**
  - The transcoded word loads into o_tx_coded, o_valid is set, and o_tc_count increments.
  - o_tx_coded is held stable while o_valid && !i_ready.
  - o_valid clears on i_ready unless a new word loads in the same cycle.
- **Ready.** o_ready = !(slot == 3 && o_valid && !i_ready). Slots 0–2 always accept.
- **Counters.** 32-bit, wrap modulo 2^32. Both can increment in the same cycle.

## Timing
- **Reset values.** On reset (asynchronous), and until the first load:
  - o_valid = 0;
  - o_tx_coded = 0;
  - o_tc_count = 0;
  - o_err_count = 0;
  - slot = 0;
  - o_ready = 1.
- **Latency.** A 4th block accepted at edge N produces o_valid = 1 with the word after edge N, i.e. one cycle of latency.
- **Throughput.** One 66b block per cycle with i_ready held high, giving an o_valid duty cycle of 1/4.
- **Simultaneous drain and load.** The old word is consumed, the new word loads, and o_valid stays 1.
- **i_valid low.** Slot and buffer hold; there is no timeout.
- **Reset mid-group.** The partial group is discarded and the next accepted block goes to slot 0.
- **Combinational path.** o_ready depends combinationally on i_ready, so the downstream must not derive i_ready from o_ready.

## Test plan
- **All data.** Four data blocks, i_data = 64'hAAAAAAAAAAAAAAAA, i_sh = 01 -> one cycle later:
  - o_valid = 1;
  - o_tx_coded[0] = 1;
  - [256:1] = {4{64'hAA..AA}};
  - o_tc_count = 1.
- **Mixed, control in slot 2.** Sequence D0, D1, control 0x1E with payload {8{7'h1E}}, D3 (all data = AA pattern) -> o_tx_coded:
  - [0] = 0;
  - [4:1] = 4'b1011;
  - [5+:64] = D0 and [69+:64] = D1;
  - [133+:4] = 4'h1;
  - [137+:56] = {8{7'h1E}};
  - [193+:64] = D3.
- **Start block in slot 0.** Start block 0x78 in slot 0 with data 56'hAA.., followed by three data blocks -> [4:1] = 4'b1110, [5+:4] = 4'h7, [9+:56] = {7{8'hAA}}.
- **Error replacement.** One block with i_sh = 2'b11 and one control block with type 8'h55, within one group -> both are encoded as type nibble 1 / 0x1E with {8{ERR_CHAR}} payload, and o_err_count = 2.
- **Backpressure.** i_ready = 0 with 8 blocks offered back-to-back:
  - the first word is held stable;
  - o_ready = 0 at slot 3, and the 8th block waits;
  - raising i_ready drains word 1 and loads word 2 the next cycle;
  - no block is lost and o_tc_count = 2.
- **Reset mid-group.** Assert i_rst after 2 accepted blocks -> all outputs are 0. The following 4 data blocks produce exactly one word, containing only the post-reset blocks.
